syscall_halt_ctrl: RTL and testbench

//  Run/halt sequencer for the single-cycle MIPS core. Sits between the decoder/register file and the PC register.
//  On each SYSCALL it inspects $v0 (R1 port forced to reg 2) and $a0 (R2 port forced to reg 4).
//  It then prints, pauses or exits the core. It drives the PC write enable and counts executed instructions and syscalls for the board display.

---
 rtl/syscall_pkg.sv | 17 +
 rtl/go_edge_sync.sv | 36 +++
 rtl/syscall_halt_ctrl.sv | 122 ++++++++++++
 tb/tb_syscall_halt_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared types and default service codes for the run/halt sequencer.
package syscall_pkg;

    // Sequencer states: normal execution, paused on a syscall, single
    // step past the pausing syscall, and permanent stop.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESUME = 2'd2,
        ST_EXIT   = 2'd3
    } state_e;

    // $v0 service codes recognised on SYSCALL.
    localparam logic [31:0] SVC_PRINT_DEF = 32'h0000_0022;
    localparam logic [31:0] SVC_EXIT_DEF  = 32'h0000_000A;

endpackage

// File: rtl/go_edge_sync.sv
// Synchronises the asynchronous Go button into the core clock domain and
// produces a single-cycle pulse on each rising edge of the synchronised level.
module go_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go_async,
    output logic go_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the button level through the chain; remember last stage for edge detect.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], go_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and edge flop registers, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign go_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/syscall_halt_ctrl.sv
// Run/halt sequencer for the single-cycle MIPS core: decodes SYSCALL
// services from $v0, gates the PC write enable, latches printed values
// for the board display and keeps saturating retire counters.
module syscall_halt_ctrl
    import syscall_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] SVC_PRINT   = SVC_PRINT_DEF,
    parameter logic [31:0] SVC_EXIT    = SVC_EXIT_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syscall,
    input  logic [31:0]      v0_val,
    input  logic [31:0]      a0_val,
    input  logic             go_async,
    output logic             pc_en,
    output logic             halted,
    output logic             done,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] sys_cnt
);

    state_e             state_q, state_d;
    logic [31:0]        disp_data_q, disp_data_d;
    logic               disp_valid_q, disp_valid_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]   sys_cnt_q, sys_cnt_d;
    logic               go_rise;
    logic               is_print;
    logic               is_exit;
    logic               sys_taken;

    go_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_go_sync (
        .clk      (clk),
        .rst      (rst),
        .go_async (go_async),
        .go_rise  (go_rise)
    );

    // Full 32-bit service decode; only meaningful while running.
    assign is_print  = (v0_val == SVC_PRINT);
    assign is_exit   = (v0_val == SVC_EXIT);
    assign sys_taken = (state_q == ST_RUN) && syscall;

    // Next-state, PC enable and display latch decode.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!syscall) begin
                    pc_en = 1'b1;
                end else if (is_print) begin
                    pc_en        = 1'b1;
                    disp_data_d  = a0_val;
                    disp_valid_d = 1'b1;
                end else if (is_exit) begin
                    state_d = ST_EXIT;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (go_rise) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                // Step past the pausing SYSCALL without re-decoding it.
                pc_en   = 1'b1;
                state_d = ST_RUN;
            end
            ST_EXIT: begin
                state_d = ST_EXIT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating retire counters: hold at all-ones instead of wrapping.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        sys_cnt_d   = sys_cnt_q;
        if (pc_en && !(&instr_cnt_q)) instr_cnt_d = instr_cnt_q + CNT_W'(1);
        if (sys_taken && !(&sys_cnt_q)) sys_cnt_d = sys_cnt_q + CNT_W'(1);
    end

    // State, display and counter registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            instr_cnt_q  <= '0;
            sys_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            instr_cnt_q  <= instr_cnt_d;
            sys_cnt_q    <= sys_cnt_d;
        end
    end

    assign halted     = (state_q == ST_HALT);
    assign done       = (state_q == ST_EXIT);
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign instr_cnt  = instr_cnt_q;
    assign sys_cnt    = sys_cnt_q;

endmodule

// File: tb/tb_syscall_halt_ctrl.sv
// Scoreboard bench for the run/halt sequencer. Two instances share all
// inputs: a 32-bit counter build and a 4-bit build for saturation.
module tb_syscall_halt_ctrl;

    localparam int          S      = 2;
    localparam logic [31:0] PRINT  = 32'h22;
    localparam logic [31:0] EXITC  = 32'h0A;

    // Reference model modes.
    localparam int RUNNING  = 0;
    localparam int PAUSED   = 1;
    localparam int STEPPING = 2;
    localparam int FINISHED = 3;

    typedef struct {
        bit          pc_en;
        bit          halted;
        bit          done;
        bit          disp_valid;
        bit [31:0]   disp_data;
        longint      instr;
        longint      sys;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        syscall = 1'b0;
    logic [31:0] v0_val = '0;
    logic [31:0] a0_val = '0;
    logic        go_async = 1'b0;

    logic        pc_en, halted, done, disp_valid;
    logic [31:0] disp_data;
    logic [31:0] instr_cnt, sys_cnt;
    logic        pc_en4, halted4, done4, disp_valid4;
    logic [31:0] disp_data4;
    logic [3:0]  instr_cnt4, sys_cnt4;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [31:0]   print_q[$];

    // Model state.
    int          mode = RUNNING;
    longint      icount = 0;
    longint      scount = 0;
    bit [31:0]   m_disp = '0;
    bit          m_valid = 1'b0;
    bit          go_hist [0:S];

    always #5 clk = ~clk;

    syscall_halt_ctrl #(.CNT_W(32), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .syscall(syscall), .v0_val(v0_val), .a0_val(a0_val),
        .go_async(go_async), .pc_en(pc_en), .halted(halted), .done(done),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .instr_cnt(instr_cnt), .sys_cnt(sys_cnt)
    );

    syscall_halt_ctrl #(.CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst(rst), .syscall(syscall), .v0_val(v0_val), .a0_val(a0_val),
        .go_async(go_async), .pc_en(pc_en4), .halted(halted4), .done(done4),
        .disp_data(disp_data4), .disp_valid(disp_valid4),
        .instr_cnt(instr_cnt4), .sys_cnt(sys_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // One cycle of the reference model: record what the outputs must be for
    // the inputs now applied, then advance across the clock edge.
    task automatic model_cycle();
        exp_t e;
        bit   rise;
        bit   pc;
        rise = go_hist[S-1] & ~go_hist[S];
        pc = (mode == STEPPING) || (mode == RUNNING && (!syscall || v0_val == PRINT));
        e.pc_en      = pc;
        e.halted     = (mode == PAUSED);
        e.done       = (mode == FINISHED);
        e.disp_valid = m_valid;
        e.disp_data  = m_disp;
        e.instr      = icount;
        e.sys        = scount;
        exp_q.push_back(e);

        if (rst) begin
            mode    = RUNNING;
            icount  = 0;
            scount  = 0;
            m_disp  = '0;
            m_valid = 1'b0;
            for (int k = 0; k <= S; k++) go_hist[k] = 1'b0;
        end else begin
            for (int k = S; k > 0; k--) go_hist[k] = go_hist[k-1];
            go_hist[0] = go_async;
            if (pc) icount++;
            m_valid = 1'b0;
            case (mode)
                RUNNING: if (syscall) begin
                    scount++;
                    if (v0_val == PRINT) begin
                        m_disp  = a0_val;
                        m_valid = 1'b1;
                        print_q.push_back(a0_val);
                    end else if (v0_val == EXITC) begin
                        mode = FINISHED;
                    end else begin
                        mode = PAUSED;
                    end
                end
                PAUSED:   if (rise) mode = STEPPING;
                STEPPING: mode = RUNNING;
                default:  ;
            endcase
        end
    endtask

    task automatic drive(input bit r, input bit s, input logic [31:0] v0,
                         input logic [31:0] a0, input bit g);
        @(negedge clk);
        rst      = r;
        syscall  = s;
        v0_val   = v0;
        a0_val   = a0;
        go_async = g;
        model_cycle();
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom, g);
    endtask

    // Monitor: pop one expectation per cycle and compare; also match each
    // display pulse against the queue of printed values.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_en",       pc_en,      e.pc_en);
                check("halted",      halted,     e.halted);
                check("done",        done,       e.done);
                check("disp_valid",  disp_valid, e.disp_valid);
                check("disp_data",   disp_data,  e.disp_data);
                check("instr_cnt",   instr_cnt,  sat(e.instr, 32));
                check("sys_cnt",     sys_cnt,    sat(e.sys, 32));
                check("pc_en_w4",    pc_en4,     e.pc_en);
                check("halted_w4",   halted4,    e.halted);
                check("instr_cnt_w4", instr_cnt4, sat(e.instr, 4));
                check("sys_cnt_w4",  sys_cnt4,   sat(e.sys, 4));
                if (disp_valid === 1'b1) begin
                    if (print_q.size() == 0) check("print_unexpected", 1, 0);
                    else check("print_value", disp_data, print_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int r;
        logic [31:0] v;
        for (int k = 0; k <= S; k++) go_hist[k] = 1'b0;
        repeat (3) @(posedge clk);

        // Free running.
        idle(10, 1'b0);
        // Print, then back-to-back prints.
        drive(1'b0, 1'b1, PRINT, 32'hDEADBEEF, 1'b0);
        idle(2, 1'b0);
        drive(1'b0, 1'b1, PRINT, 32'h1111_2222, 1'b0);
        drive(1'b0, 1'b1, PRINT, 32'h3333_4444, 1'b0);
        idle(2, 1'b0);
        // Pause, then a Go pulse.
        drive(1'b0, 1'b1, 32'h05, 32'h0, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);
        idle(6, 1'b0);
        // Near-miss of the print code must pause, not print.
        drive(1'b0, 1'b1, 32'h8000_0022, 32'h55, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(6, 1'b0);
        // Go already held when pausing: needs a fresh press.
        idle(4, 1'b1);
        drive(1'b0, 1'b1, 32'h07, 32'h0, 1'b1);
        idle(6, 1'b1);
        idle(3, 1'b0);
        idle(2, 1'b1);
        idle(6, 1'b0);
        // Exit ignores Go until reset.
        drive(1'b0, 1'b1, EXITC, 32'h0, 1'b0);
        for (int i = 0; i < 50; i++) idle(1, 1'($urandom_range(0, 1)));
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(2, 1'b0);
        // Saturation of the narrow counter, then reset while paused.
        idle(20, 1'b0);
        drive(1'b0, 1'b1, 32'h03, 32'h0, 1'b0);
        idle(3, 1'b0);
        drive(1'b1, 1'b1, PRINT, 32'h99, 1'b1);
        idle(3, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: v = PRINT;
                5:             v = EXITC;
                6:             v = PRINT ^ (32'h1 << $urandom_range(0, 31));
                default:       v = $urandom;
            endcase
            drive((mode == FINISHED) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 4) == 0), v, $urandom,
                  ($urandom_range(0, 5) == 0) ? ~go_async : go_async);
        end

        idle(2, 1'b0);
        @(negedge clk);
        #5;
        check("exp_queue_drained", exp_q.size(), 0);
        check("print_queue_drained", print_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
